conv_output_arrange: RTL and testbench

- Reorders convolution-array output from channel-group-major order into pixel-major (HWC) order for the next layer.
- Input arrives per 8-channel group as a whole feature map, one 64-bit beat (8 channel bytes) per pixel.
- Output emits, for each pixel, all In_Channel/8 beats contiguously.
- Sits between the systolic conv output and the downstream stream; it buffers one full layer in internal RAM, then drains it.

---
 rtl/conv_output_arrange_pkg.sv | 15 +
 rtl/conv_output_arrange_ram.sv | 27 ++
 rtl/conv_output_arrange.sv | 204 ++++++++++++++++++++
 tb/tb_conv_output_arrange.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_output_arrange_pkg.sv
// Shared types and constants for the conv output reorder block.
// Beat geometry and the layer-sequencing state enum.
package conv_output_arrange_pkg;

  localparam int unsigned ARR_DATA_W = 64;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned LANES      = ARR_DATA_W / LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/conv_output_arrange_ram.sv
// Layer buffer: synchronous RAM, one write port, one read port.
// Read data is registered and held while no read is issued.
module arrange_buf_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned W     = 64,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_output_arrange.sv
// Buffers one channel-group-major layer, then drains it pixel-major.
// RAM read register is the output stage; a skid entry absorbs stalls.
module conv_output_arrange
  import conv_output_arrange_pkg::*;
#(
  parameter int unsigned DATA_W    = ARR_DATA_W,
  parameter int unsigned BUF_DEPTH = 4096,
  parameter int unsigned CH_W      = 16,
  parameter int unsigned DIM_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CH_W-1:0]   In_Channel,
  input  logic [DIM_W-1:0]  Matrix_Col,
  input  logic [DIM_W-1:0]  Matrix_Row,
  input  logic [DATA_W-1:0] sData,
  input  logic              sValid,
  output logic              sReady,
  output logic [DATA_W-1:0] mData_payload,
  output logic              mData_valid,
  input  logic              mData_ready,
  output logic              mData_last
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned PW = 2 * DIM_W;
  localparam int unsigned GW = CH_W - 3;
  localparam int unsigned NW = PW + GW;

  state_e st_q, st_d;

  logic [PW-1:0] p_tot_q, p_tot_d;
  logic [GW-1:0] g_tot_q, g_tot_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] wr_cnt_q, wr_cnt_d;

  logic [PW-1:0] p_cnt_q, p_cnt_d;
  logic [GW-1:0] g_cnt_q, g_cnt_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_done_q, rd_done_d;

  logic              rv_q, rv_d;
  logic              rlast_q, rlast_d;
  logic              skid_v_q, skid_v_d;
  logic              skid_last_q, skid_last_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic [PW-1:0]     cfg_p;
  logic [GW-1:0]     cfg_g;
  logic [NW-1:0]     cfg_n;
  logic              wr_fire, wr_end;
  logic              out_v, out_fire, hold;
  logic              rd_en, rd_last, g_wrap, p_wrap;
  logic [DATA_W-1:0] ram_q;
  logic              unused_ch;

  assign unused_ch = ^In_Channel[2:0];

  assign cfg_p = PW'(Matrix_Row) * PW'(Matrix_Col);
  assign cfg_g = In_Channel[CH_W-1:3];
  assign cfg_n = NW'(cfg_p) * NW'(cfg_g);

  assign sReady  = (st_q == ST_FILL);
  assign wr_fire = sReady && sValid;
  assign wr_end  = wr_fire && (wr_cnt_q == n_q - NW'(1));

  assign out_v    = skid_v_q || rv_q;
  assign out_fire = out_v && mData_ready;
  // Both stages full and nothing leaving: RAM output must not change.
  assign hold     = rv_q && skid_v_q && !out_fire;

  assign g_wrap  = (g_cnt_q == g_tot_q - GW'(1));
  assign p_wrap  = (p_cnt_q == p_tot_q - PW'(1));
  assign rd_last = g_wrap && p_wrap;
  assign rd_en   = (st_q == ST_DRAIN) && !rd_done_q && !hold;

  assign mData_valid   = out_v;
  assign mData_payload = skid_v_q ? skid_q
                       : (rv_q ? ram_q : '0);
  assign mData_last    = skid_v_q ? skid_last_q
                       : (rv_q && rlast_q);

  arrange_buf_ram #(
    .DEPTH (BUF_DEPTH),
    .W     (DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_cnt_q[AW-1:0]),
    .wdata_i (sData),
    .re_i    (rd_en),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_q)
  );

  always_comb begin
    st_d      = st_q;
    p_tot_d   = p_tot_q;
    g_tot_d   = g_tot_q;
    n_d       = n_q;
    wr_cnt_d  = wr_cnt_q;
    p_cnt_d   = p_cnt_q;
    g_cnt_d   = g_cnt_q;
    rd_base_d = rd_base_q;
    rd_addr_d = rd_addr_q;
    rd_done_d = rd_done_q;
    unique case (st_q)
      ST_IDLE: begin
        if (start && cfg_p != '0 && cfg_g != '0) begin
          st_d      = ST_FILL;
          p_tot_d   = cfg_p;
          g_tot_d   = cfg_g;
          n_d       = cfg_n;
          wr_cnt_d  = '0;
          p_cnt_d   = '0;
          g_cnt_d   = '0;
          rd_base_d = '0;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (wr_fire) wr_cnt_d = wr_cnt_q + NW'(1);
        if (wr_end) st_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_fire && mData_last) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    // Walk g inner, p outer: step by P within a pixel, then base+1.
    if (rd_en) begin
      if (g_wrap) begin
        g_cnt_d   = '0;
        p_cnt_d   = p_cnt_q + PW'(1);
        rd_base_d = rd_base_q + AW'(1);
        rd_addr_d = rd_base_q + AW'(1);
      end else begin
        g_cnt_d   = g_cnt_q + GW'(1);
        rd_addr_d = rd_addr_q + AW'(p_tot_q);
      end
      if (rd_last) rd_done_d = 1'b1;
    end
  end

  always_comb begin
    skid_v_d    = skid_v_q;
    skid_d      = skid_q;
    skid_last_d = skid_last_q;
    if (skid_v_q) begin
      if (out_fire) begin
        skid_v_d    = rv_q;
        skid_d      = ram_q;
        skid_last_d = rlast_q;
      end
    end else if (rv_q && !out_fire) begin
      skid_v_d    = 1'b1;
      skid_d      = ram_q;
      skid_last_d = rlast_q;
    end
    rv_d    = rd_en || hold;
    rlast_d = rd_en ? rd_last : rlast_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      p_tot_q     <= '0;
      g_tot_q     <= '0;
      n_q         <= '0;
      wr_cnt_q    <= '0;
      p_cnt_q     <= '0;
      g_cnt_q     <= '0;
      rd_base_q   <= '0;
      rd_addr_q   <= '0;
      rd_done_q   <= 1'b0;
      rv_q        <= 1'b0;
      rlast_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      st_q        <= st_d;
      p_tot_q     <= p_tot_d;
      g_tot_q     <= g_tot_d;
      n_q         <= n_d;
      wr_cnt_q    <= wr_cnt_d;
      p_cnt_q     <= p_cnt_d;
      g_cnt_q     <= g_cnt_d;
      rd_base_q   <= rd_base_d;
      rd_addr_q   <= rd_addr_d;
      rd_done_q   <= rd_done_d;
      rv_q        <= rv_d;
      rlast_q     <= rlast_d;
      skid_v_q    <= skid_v_d;
      skid_last_q <= skid_last_d;
      skid_q      <= skid_d;
    end
  end

endmodule

// File: tb/tb_conv_output_arrange.sv
// Directed bench for conv_output_arrange: table of layers plus
// hand sequences for bad starts and reset during drain.
module tb_conv_output_arrange;

  typedef struct {
    int row;
    int col;
    int ch;
    int in_mode;
    int out_mode;
    int inj;
    int exp_n;
    int exp_second;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] In_Channel;
  logic [7:0]  Matrix_Col;
  logic [7:0]  Matrix_Row;
  logic [63:0] sData;
  logic        sValid;
  logic        sReady;
  logic [63:0] mData_payload;
  logic        mData_valid;
  logic        mData_ready;
  logic        mData_last;

  int total = 0;
  int bad   = 0;
  vec_t vecs[5];

  conv_output_arrange dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .In_Channel    (In_Channel),
    .Matrix_Col    (Matrix_Col),
    .Matrix_Row    (Matrix_Row),
    .sData         (sData),
    .sValid        (sValid),
    .sReady        (sReady),
    .mData_payload (mData_payload),
    .mData_valid   (mData_valid),
    .mData_ready   (mData_ready),
    .mData_last    (mData_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {16'hA5C3, kk, 16'h3C5A ^ kk, kk};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_layer(input vec_t v, input int abort_at);
    int p_n, g_n, n, sent, cyc, first_v, acc_last, budget, j;
    logic [63:0] got[$];
    bit          lastf[$];
    logic [63:0] exp_q[$];
    logic [63:0] p_pay;
    logic        p_last, pv_stall;
    bit          done, aborted;
    p_n = v.row * v.col;
    g_n = v.ch >> 3;
    n   = p_n * g_n;
    for (int p = 0; p < p_n; p++)
      for (int g = 0; g < g_n; g++)
        exp_q.push_back(beat(g * p_n + p));
    Matrix_Row = 8'(v.row);
    Matrix_Col = 8'(v.col);
    In_Channel = 16'(v.ch);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Matrix_Row = 8'd1;
    Matrix_Col = 8'd1;
    In_Channel = 16'd8;
    chk("sready_after_start", 64'(sReady), 64'd1);
    sent = 0; cyc = 0; first_v = -1; acc_last = -1;
    done = 0; aborted = 0; pv_stall = 0;
    p_pay = '0; p_last = 0;
    budget = 4 * n + 40;
    while (!done && cyc < budget) begin
      mData_ready = (v.out_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      sValid = (sent < n) && (v.in_mode == 0 || (cyc % 3) != 2);
      sData  = beat(sent);
      start  = 1'b0;
      if (v.inj != 0 && cyc == 2) start = 1'b1;
      if (v.inj != 0 && mData_valid && first_v < 0) start = 1'b1;
      if (pv_stall) begin
        chk("stall_payload", mData_payload, p_pay);
        chk("stall_last", 64'(mData_last), 64'(p_last));
      end
      pv_stall = mData_valid && !mData_ready;
      p_pay  = mData_payload;
      p_last = mData_last;
      if (sValid && sReady) begin
        if (sent == n - 1) acc_last = cyc;
        sent++;
      end
      if (mData_valid && first_v < 0) first_v = cyc;
      if (mData_valid && mData_ready) begin
        got.push_back(mData_payload);
        lastf.push_back(mData_last);
        if (mData_last) done = 1;
        if (abort_at > 0 && got.size() == abort_at) begin
          done = 1;
          aborted = 1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    sValid = 1'b0;
    start = 1'b0;
    mData_ready = 1'b1;
    if (aborted) return;
    chk("layer_done", 64'(done), 64'd1);
    chk("beat_count", 64'(got.size()), 64'(v.exp_n));
    j = 0;
    foreach (got[i]) begin
      if (i < n) begin
        chk($sformatf("beat[%0d]", i), got[i], exp_q[i]);
        chk($sformatf("last[%0d]", i), 64'(lastf[i]),
            64'(i == n - 1));
      end
      j++;
    end
    if (j > 1) chk("second_beat", got[1], beat(v.exp_second));
    chk("first_latency", 64'(first_v - acc_last), 64'd2);
    chk("idle_sready", 64'(sReady), 64'd0);
    chk("idle_valid", 64'(mData_valid), 64'd0);
  endtask

  task automatic bad_start(input int row, input int col, input int ch);
    Matrix_Row = 8'(row);
    Matrix_Col = 8'(col);
    In_Channel = 16'(ch);
    sValid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("badstart_sready", 64'(sReady), 64'd0);
      chk("badstart_valid", 64'(mData_valid), 64'd0);
      @(negedge clk);
    end
    sValid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2, 2, 16, 0, 0, 1, 8, 4};
    vecs[1] = '{14, 14, 32, 0, 0, 0, 784, 196};
    vecs[2] = '{2, 2, 16, 1, 1, 0, 8, 4};
    vecs[3] = '{1, 3, 8, 0, 0, 0, 3, 1};
    vecs[4] = '{3, 1, 24, 0, 1, 0, 9, 3};
    reset = 1'b1;
    start = 1'b0;
    In_Channel = '0;
    Matrix_Col = '0;
    Matrix_Row = '0;
    sData = '0;
    sValid = 1'b0;
    mData_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_sready", 64'(sReady), 64'd0);
    chk("rst_valid", 64'(mData_valid), 64'd0);
    chk("rst_last", 64'(mData_last), 64'd0);
    chk("rst_payload", mData_payload, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_layer(vecs[i], 0);
    bad_start(2, 2, 0);
    bad_start(2, 2, 7);
    bad_start(0, 4, 16);
    run_layer(vecs[2], 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(mData_valid), 64'd0);
    chk("midrst_sready", 64'(sReady), 64'd0);
    chk("midrst_last", 64'(mData_last), 64'd0);
    chk("midrst_payload", mData_payload, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_valid", 64'(mData_valid), 64'd0);
    run_layer(vecs[0], 0);
    run_layer(vecs[4], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
